// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: lock FSM states, port ids and
// the read-owner pipeline stage.
package mem_arb_pkg;

    localparam int MEM_AW  = 10;
    localparam int MEM_DW  = 32;
    localparam int LOCK_CW = 8;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCK0    = 2'd1,
        LOCK1    = 2'd2
    } lock_state_t;

    typedef enum logic {
        P0 = 1'b0,
        P1 = 1'b1
    } port_t;

    typedef struct packed {
        logic  valid;
        port_t port;
    } owner_t;

    function automatic port_t other_port(input port_t p);
        return (p == P0) ? P1 : P0;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection. MEM_ARB_RR_EN selects round-robin between
// simultaneous unlocked requesters; otherwise port 0 has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic        req0,
    input  logic        req1,
    input  lock_state_t state,
`ifdef MEM_ARB_RR_EN
    input  port_t       last,
`endif
    input  logic        esc,
    input  port_t       esc_port,
    output logic        gnt0,
    output logic        gnt1
);

    port_t win;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        win  = P0;
        case (state)
            LOCK0: gnt0 = req0;
            LOCK1: gnt1 = req1;
            default: begin
                if (req0 && req1) begin
                    // A burst that hit its limit hands the next slot to the other port
                    if (esc) begin
                        win = esc_port;
                    end else begin
`ifdef MEM_ARB_RR_EN
                        win = other_port(last);
`else
                        win = P0;
`endif
                    end
                    gnt0 = (win == P0);
                    gnt1 = (win == P1);
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arb.sv
// Two-port arbiter/sequencer for a single-port RAM with one-cycle read latency
// and bounded locked bursts. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int AW       = MEM_AW,
    parameter int DW       = MEM_DW,
    parameter int LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam logic [LOCK_CW-1:0] LOCK_LIM = LOCK_CW'(LOCK_MAX);

    lock_state_t        state_reg, state_next;
    logic [LOCK_CW-1:0] lock_cnt_reg, lock_cnt_next, cnt_inc;
    logic               esc_reg, esc_next;
    port_t              esc_port_reg, esc_port_next;
    owner_t             st1_reg, st2_reg, st1_next;
    logic               pick_gnt0, pick_gnt1;
    logic               xfer, g_we, g_lock;
    port_t              g_port, own_port;
    logic [AW-1:0]      g_addr;
    logic [DW-1:0]      g_wdata;
    logic               own_req, own_lock, own_gnt;

`ifdef MEM_ARB_RR_EN
    port_t last_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= P1;
        end else if (xfer && state_reg == UNLOCKED) begin
            last_reg <= g_port;
        end
    end
`endif

    mem_arb_pick u_pick (
        .req0     (req0),
        .req1     (req1),
        .state    (state_reg),
`ifdef MEM_ARB_RR_EN
        .last     (last_reg),
`endif
        .esc      (esc_reg),
        .esc_port (esc_port_reg),
        .gnt0     (pick_gnt0),
        .gnt1     (pick_gnt1)
    );

    assign gnt0     = pick_gnt0 & rst_n;
    assign gnt1     = pick_gnt1 & rst_n;
    assign xfer     = gnt0 | gnt1;
    assign g_port   = gnt1 ? P1 : P0;
    assign g_we     = gnt1 ? we1 : we0;
    assign g_lock   = gnt1 ? lock1 : lock0;
    assign g_addr   = gnt1 ? addr1 : addr0;
    assign g_wdata  = gnt1 ? wdata1 : wdata0;

    assign own_port = (state_reg == LOCK1) ? P1 : P0;
    assign own_req  = (own_port == P1) ? req1 : req0;
    assign own_lock = (own_port == P1) ? lock1 : lock0;
    assign own_gnt  = (own_port == P1) ? gnt1 : gnt0;
    assign cnt_inc  = lock_cnt_reg + LOCK_CW'(1);

    // The grant that opens a burst is counted as its first locked grant
    always_comb begin
        state_next    = state_reg;
        lock_cnt_next = lock_cnt_reg;
        esc_next      = 1'b0;
        esc_port_next = esc_port_reg;
        case (state_reg)
            UNLOCKED: begin
                if (xfer && g_lock) begin
                    if (LOCK_LIM == LOCK_CW'(1)) begin
                        esc_next      = 1'b1;
                        esc_port_next = other_port(g_port);
                    end else begin
                        state_next    = (g_port == P1) ? LOCK1 : LOCK0;
                        lock_cnt_next = LOCK_CW'(1);
                    end
                end
            end
            default: begin
                if (own_gnt) begin
                    if (!own_lock) begin
                        state_next    = UNLOCKED;
                        lock_cnt_next = '0;
                    end else if (cnt_inc == LOCK_LIM) begin
                        state_next    = UNLOCKED;
                        lock_cnt_next = '0;
                        esc_next      = 1'b1;
                        esc_port_next = other_port(own_port);
                    end else begin
                        lock_cnt_next = cnt_inc;
                    end
                end else if (!own_req && !own_lock) begin
                    state_next    = UNLOCKED;
                    lock_cnt_next = '0;
                end
            end
        endcase
    end

    assign st1_next = '{valid: xfer & ~g_we, port: g_port};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= UNLOCKED;
            lock_cnt_reg <= '0;
            esc_reg      <= 1'b0;
            esc_port_reg <= P0;
            st1_reg      <= '0;
            st2_reg      <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_din      <= '0;
        end else begin
            state_reg    <= state_next;
            lock_cnt_reg <= lock_cnt_next;
            esc_reg      <= esc_next;
            esc_port_reg <= esc_port_next;
            st1_reg      <= st1_next;
            st2_reg      <= st1_reg;
            mem_we       <= xfer & g_we;
            if (xfer) begin
                mem_addr <= g_addr;
                mem_din  <= g_wdata;
            end
        end
    end

    assign rvalid0 = st2_reg.valid && (st2_reg.port == P0);
    assign rvalid1 = st2_reg.valid && (st2_reg.port == P1);
    assign rdata   = mem_dout;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed vector table, lock-burst and reset
// sequences, then random traffic against a spec-level model and scoreboard.
module tb_mem_port_arb;

    localparam int AW       = 10;
    localparam int DW       = 32;
    localparam int LOCK_MAX = 8;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic          lock0 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [DW-1:0] rdata, mem_din, mem_dout;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_port_arb #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Behavioural single-port RAM, one-cycle registered read
    logic [DW-1:0] ram [1024];
    initial for (int i = 0; i < 1024; i++) ram[i] = '0;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } rd_t;

    rd_t         rq[$];
    logic [31:0] m_mem [1024];
    int          m_owner, m_burst, m_last, m_fav, m_gnt, cyc;
    logic        exp_we;
    logic [9:0]  exp_addr;
    logic [31:0] exp_din;

    initial for (int i = 0; i < 1024; i++) m_mem[i] = '0;

    task automatic model_reset();
        m_owner  = -1;
        m_burst  = 0;
        m_last   = 1;
        m_fav    = -1;
        m_gnt    = -1;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_din  = '0;
        rq.delete();
    endtask

    function automatic int model_grant();
        if (m_owner == 0) return req0 ? 0 : -1;
        if (m_owner == 1) return req1 ? 1 : -1;
        if (req0 && req1) begin
            if (m_fav >= 0) return m_fav;
            return RR ? 1 - m_last : 0;
        end
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    task automatic model_update(input int g);
        logic lk;
        int   nf;
        nf = -1;
        lk = (g == 1) ? lock1 : lock0;
        if (m_owner < 0) begin
            if (g >= 0) begin
                m_last = g;
                if (lk) begin
                    m_burst = 1;
                    if (m_burst == LOCK_MAX) nf = 1 - g;
                    else m_owner = g;
                end
            end
        end else if (g == m_owner) begin
            if (!lk) begin
                m_owner = -1;
            end else begin
                m_burst++;
                if (m_burst == LOCK_MAX) begin
                    m_owner = -1;
                    nf = 1 - g;
                end
            end
        end else if (!((m_owner == 1) ? req1 : req0) && !((m_owner == 1) ? lock1 : lock0)) begin
            m_owner = -1;
        end
        m_fav = nf;
    endtask

    // Checks every cycle's outputs against the model, then commits the transfer
    always @(negedge clk) begin
        logic        ev0, ev1, w;
        logic [31:0] ed, d;
        logic [9:0]  a;
        int          g;
        if (!rst_n) begin
            check("rst_gnt0", 32'(gnt0), 32'd0);
            check("rst_gnt1", 32'(gnt1), 32'd0);
            check("rst_rvalid0", 32'(rvalid0), 32'd0);
            check("rst_rvalid1", 32'(rvalid1), 32'd0);
            check("rst_mem_we", 32'(mem_we), 32'd0);
            model_reset();
        end else begin
            ev0 = 1'b0;
            ev1 = 1'b0;
            ed  = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                ev0 = (rq[0].port == 0);
                ev1 = (rq[0].port == 1);
                ed  = rq[0].data;
                void'(rq.pop_front());
            end
            check("rvalid0", 32'(rvalid0), 32'(ev0));
            check("rvalid1", 32'(rvalid1), 32'(ev1));
            if (ev0 || ev1) check("rdata", rdata, ed);
            check("mem_we", 32'(mem_we), 32'(exp_we));
            check("mem_addr", 32'(mem_addr), 32'(exp_addr));
            check("mem_din", mem_din, exp_din);
            g = model_grant();
            check("gnt0", 32'(gnt0), 32'(g == 0));
            check("gnt1", 32'(gnt1), 32'(g == 1));
            exp_we = 1'b0;
            if (g >= 0) begin
                w = (g == 1) ? we1 : we0;
                a = (g == 1) ? addr1 : addr0;
                d = (g == 1) ? wdata1 : wdata0;
                exp_we   = w;
                exp_addr = a;
                exp_din  = d;
                if (w) m_mem[a] = d;
                else rq.push_back('{port: g, data: m_mem[a], due: cyc + 2});
                $display("xfer cyc=%0d port=%0d %s addr=0x%03h data=0x%08h",
                         cyc, g, w ? "WR" : "RD", a, w ? d : m_mem[a]);
            end
            model_update(g);
            m_gnt = g;
            cyc++;
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r0, w0, l0;
        logic [9:0]  a0;
        logic [31:0] d0;
        logic        r1, w1, l1;
        logic [9:0]  a1;
        logic [31:0] d1;
        logic        eg0, eg1, erv0, erv1;
        logic [31:0] erd;
    } vec_t;

    localparam int NV = 12;
    vec_t vec[NV];

    function automatic vec_t mk(input logic r0, w0, l0, input logic [9:0] a0, input logic [31:0] d0,
                                input logic r1, w1, l1, input logic [9:0] a1, input logic [31:0] d1,
                                input logic eg0, eg1, erv0, erv1, input logic [31:0] erd);
        vec_t v;
        v = '{r0, w0, l0, a0, d0, r1, w1, l1, a1, d1, eg0, eg1, erv0, erv1, erd};
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    endtask

    logic       p_pend[2], p_we[2], p_lock[2];
    logic [9:0] p_addr[2];
    logic [31:0] p_data[2];

    initial begin
        int  seq_exp[13];
        int  n, p1n, cyc_l, got, xfers;
        bit  p0_pend;

        vec[0]  = mk(1, 1, 0, 10'h005, 32'hDEADBEEF, 0, 0, 0, 10'h000, 0, 1, 0, 0, 0, 0);
        vec[1]  = mk(1, 0, 0, 10'h005, 0,            0, 0, 0, 10'h000, 0, 1, 0, 0, 0, 0);
        vec[2]  = mk(0, 0, 0, 10'h000, 0,            0, 0, 0, 10'h000, 0, 0, 0, 0, 0, 0);
        vec[3]  = mk(0, 0, 0, 10'h000, 0,            0, 0, 0, 10'h000, 0, 0, 0, 1, 0, 32'hDEADBEEF);
        vec[4]  = mk(1, 0, 0, 10'h010, 0,            1, 0, 0, 10'h020, 0, !RR, RR, 0, 0, 0);
        vec[5]  = mk(1, 0, 0, 10'h010, 0,            1, 0, 0, 10'h020, 0, 1, 0, 0, 0, 0);
        vec[6]  = mk(1, 0, 0, 10'h010, 0,            1, 0, 0, 10'h020, 0, !RR, RR, !RR, RR, 0);
        vec[7]  = mk(1, 0, 0, 10'h010, 0,            1, 0, 0, 10'h020, 0, 1, 0, 1, 0, 0);
        vec[8]  = mk(1, 1, 0, 10'h3FF, 32'h1,        0, 0, 0, 10'h000, 0, 1, 0, !RR, RR, 0);
        vec[9]  = mk(1, 0, 0, 10'h3FF, 0,            0, 0, 0, 10'h000, 0, 1, 0, 1, 0, 0);
        vec[10] = mk(0, 0, 0, 10'h000, 0,            0, 0, 0, 10'h000, 0, 0, 0, 0, 0, 0);
        vec[11] = mk(0, 0, 0, 10'h000, 0,            0, 0, 0, 10'h000, 0, 0, 0, 1, 0, 32'h1);

        // Reset state, with a request pending to show gnt is held low
        model_reset();
        cyc  = 0;
        req0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_mem_din", mem_din, 32'd0);
        check("reset_gnt0", 32'(gnt0), 32'd0);
        check("reset_rvalid0", 32'(rvalid0), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            req0 = vec[i].r0; we0 = vec[i].w0; lock0 = vec[i].l0; addr0 = vec[i].a0; wdata0 = vec[i].d0;
            req1 = vec[i].r1; we1 = vec[i].w1; lock1 = vec[i].l1; addr1 = vec[i].a1; wdata1 = vec[i].d1;
            @(negedge clk);
            check($sformatf("vec%0d_gnt0", i), 32'(gnt0), 32'(vec[i].eg0));
            check($sformatf("vec%0d_gnt1", i), 32'(gnt1), 32'(vec[i].eg1));
            check($sformatf("vec%0d_rvalid0", i), 32'(rvalid0), 32'(vec[i].erv0));
            check($sformatf("vec%0d_rvalid1", i), 32'(rvalid1), 32'(vec[i].erv1));
            if (vec[i].erv0 || vec[i].erv1) check($sformatf("vec%0d_rdata", i), rdata, vec[i].erd);
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // Locked burst of 12 reads on port 1; port 0 posts one read meanwhile
        seq_exp = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
        n = 0; p1n = 0; cyc_l = 0; p0_pend = 1'b0;
        while (n < 13 && cyc_l < 30) begin
            req1 = (p1n < 12); we1 = 1'b0; lock1 = (p1n < 11); addr1 = 10'(10'h100 + p1n);
            req0 = p0_pend;    we0 = 1'b0; lock0 = 1'b0;      addr0 = 10'h030;
            @(negedge clk);
            if (gnt0 || gnt1) begin
                got = gnt1 ? 1 : 0;
                check($sformatf("lock_seq_%0d", n), 32'(got), 32'(seq_exp[n]));
                n++;
            end
            if (gnt1) p1n++;
            if (gnt0) p0_pend = 1'b0;
            if (cyc_l == 0) p0_pend = 1'b1;
            next_cycle();
            cyc_l++;
        end
        check("lock_seq_done", 32'(n), 32'd13);
        idle_inputs();
        repeat (3) next_cycle();

        // Reset one cycle after a read grant: the read must vanish
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'h005; wdata0 = 32'h1234;
        @(negedge clk);
        check("pre_rst_gnt0", 32'(gnt0), 32'd1);
        next_cycle();
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_we", 32'(mem_we), 32'd0);
        check("async_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("async_rst_mem_din", mem_din, 32'd0);
        check("async_rst_rvalid0", 32'(rvalid0), 32'd0);
        check("async_rst_rvalid1", 32'(rvalid1), 32'd0);
        check("async_rst_gnt0", 32'(gnt0), 32'd0);
        req0 = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_rvalid0", 32'(rvalid0), 32'd0);
            check("post_rst_rvalid1", 32'(rvalid1), 32'd0);
            next_cycle();
        end

        // Random mixed traffic; each requester holds its command until granted
        for (int p = 0; p < 2; p++) p_pend[p] = 1'b0;
        xfers = 0;
        for (int c = 0; c < 20000 && xfers < 1000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_pend[p]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        p_pend[p] = 1'b1;
                        p_we[p]   = 1'($urandom_range(0, 1));
                        p_addr[p] = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
                        p_data[p] = $urandom;
                        p_lock[p] = ($urandom_range(0, 3) == 0);
                    end else begin
                        p_lock[p] = ($urandom_range(0, 7) == 0);
                    end
                end
            end
            req0 = p_pend[0]; we0 = p_we[0]; lock0 = p_lock[0]; addr0 = p_addr[0]; wdata0 = p_data[0];
            req1 = p_pend[1]; we1 = p_we[1]; lock1 = p_lock[1]; addr1 = p_addr[1]; wdata1 = p_data[1];
            next_cycle();
            if (m_gnt >= 0) begin
                p_pend[m_gnt] = 1'b0;
                xfers++;
            end
        end
        check("random_xfers", 32'(xfers >= 1000), 32'd1);
        idle_inputs();
        repeat (4) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
